// File: rtl/rv_decode_pkg.sv
// Shared decode definitions: opcodes, ALU codes, ctrl bit positions and the
// decoded-entry record that travels through the skid buffer.
package rv_decode_pkg;

  localparam int IMM_MAX_W = 64;
  localparam int PC_MAX_W  = 64;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  localparam int CTRL_JAL        = 11;
  localparam int CTRL_JALR       = 10;
  localparam int CTRL_BRANCH     = 9;
  localparam int CTRL_MEM_READ   = 8;
  localparam int CTRL_MEM_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_ALU_SRC    = 4;

  typedef logic [11:0] ctrl_t;

  // imm/pc are held at their widest; the top trims them to XLEN/PC_W.
  typedef struct packed {
    ctrl_t                 ctrl;
    logic [IMM_MAX_W-1:0]  imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic [PC_MAX_W-1:0]   pc;
    logic                  illegal;
  } entry_t;

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV instruction decoder: raw word -> ctrl word, immediate,
// register fields and illegal flag.
module rv_decoder
  import rv_decode_pkg::*;
#(
  parameter int         XLEN   = 64,
  parameter logic [2:0] MEM_F3 = 3'd3
) (
  input  logic [31:0]         instr,
  input  logic [PC_MAX_W-1:0] pc,
  output entry_t              entry
);

  localparam logic [6:0] SRA_HI = (XLEN == 64) ? 7'b0010000 : 7'b0100000;

  logic [2:0]           f3;
  logic [6:0]           f7;
  logic [6:0]           shift_hi;
  logic [IMM_MAX_W-1:0] imm_i, imm_s, imm_b, imm_j, shamt;

  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  // RV64 shift-immediates borrow instr[25] for shamt[5], leaving six funct bits.
  assign shift_hi = (XLEN == 64) ? {1'b0, instr[31:26]} : instr[31:25];
  assign shamt    = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};

  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    entry         = '0;
    entry.rs1     = instr[19:15];
    entry.rs2     = instr[24:20];
    entry.rd      = instr[11:7];
    entry.funct3  = f3;
    entry.pc      = pc;
    entry.illegal = 1'b0;

    unique case (instr[6:0])
      OPC_OP: begin
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          entry.ctrl[CTRL_REG_WRITE] = 1'b1;
          entry.ctrl[3:0]            = {f7[5], f3};
        end else begin
          entry.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        entry.ctrl[CTRL_REG_WRITE] = 1'b1;
        entry.ctrl[CTRL_ALU_SRC]   = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          entry.imm       = shamt;
          entry.ctrl[3:0] = {shift_hi == SRA_HI, f3};
          if (!(shift_hi == 7'b0 || (f3 == 3'b101 && shift_hi == SRA_HI)))
            entry.illegal = 1'b1;
        end else begin
          entry.imm       = imm_i;
          entry.ctrl[3:0] = {1'b0, f3};
        end
      end
      OPC_LOAD: begin
        entry.ctrl[CTRL_MEM_READ]   = 1'b1;
        entry.ctrl[CTRL_MEM_TO_REG] = 1'b1;
        entry.ctrl[CTRL_REG_WRITE]  = 1'b1;
        entry.ctrl[CTRL_ALU_SRC]    = 1'b1;
        entry.ctrl[3:0]             = ALU_ADD;
        entry.imm                   = imm_i;
        entry.illegal               = (f3 != MEM_F3);
      end
      OPC_STORE: begin
        entry.ctrl[CTRL_MEM_WRITE] = 1'b1;
        entry.ctrl[CTRL_ALU_SRC]   = 1'b1;
        entry.ctrl[3:0]            = ALU_ADD;
        entry.imm                  = imm_s;
        entry.illegal              = (f3 != MEM_F3);
      end
      OPC_BRANCH: begin
        entry.ctrl[CTRL_BRANCH] = 1'b1;
        entry.ctrl[3:0]         = ALU_SUB;
        entry.imm               = imm_b;
        entry.illegal           = (f3 != 3'b000 && f3 != 3'b001);
      end
      OPC_JAL: begin
        entry.ctrl[CTRL_JAL]       = 1'b1;
        entry.ctrl[CTRL_REG_WRITE] = 1'b1;
        entry.imm                  = imm_j;
      end
      OPC_JALR: begin
        entry.ctrl[CTRL_JALR]      = 1'b1;
        entry.ctrl[CTRL_REG_WRITE] = 1'b1;
        entry.imm                  = imm_i;
      end
      default: entry.illegal = 1'b1;
    endcase

    if (entry.illegal) begin
      entry.ctrl = '0;
      entry.imm  = '0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes the incoming word and holds results in a
// 2-entry skid buffer with valid/ready on both sides, flush and illegal counter.
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int         XLEN      = 64,
  parameter int         PC_W      = 32,
  parameter logic [2:0] MEM_F3    = 3'd3,
  parameter int         ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [PC_W-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [11:0]          out_ctrl,
  output logic [XLEN-1:0]      out_imm,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_rd,
  output logic [2:0]           out_funct3,
  output logic [PC_W-1:0]      out_pc,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  logic [PC_MAX_W-1:0] pc_ext;
  entry_t              dec;
  entry_t              buf_q [2];
  entry_t              head_e;
  logic                head, tail;
  logic [1:0]          count;
  logic                push, pop;
  logic                unused_bits;

  always_comb begin
    pc_ext           = '0;
    pc_ext[PC_W-1:0] = in_pc;
  end

  rv_decoder #(
    .XLEN   (XLEN),
    .MEM_F3 (MEM_F3)
  ) u_dec (
    .instr (in_instr),
    .pc    (pc_ext),
    .entry (dec)
  );

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Empty buffer presents zeros so stale entries never leak onto out_*.
  always_comb begin
    head_e = '0;
    if (count != 2'd0) head_e = buf_q[head];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) buf_q[i] <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= '0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        buf_q[tail] <= dec;
        tail        <= ~tail;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ill_count <= '0;
    else if (pop && !flush && head_e.illegal && ill_count != '1)
      ill_count <= ill_count + 1'b1;
  end

  assign out_ctrl    = head_e.ctrl;
  assign out_imm     = head_e.imm[XLEN-1:0];
  assign out_rs1     = head_e.rs1;
  assign out_rs2     = head_e.rs2;
  assign out_rd      = head_e.rd;
  assign out_funct3  = head_e.funct3;
  assign out_pc      = head_e.pc[PC_W-1:0];
  assign out_illegal = head_e.illegal;

  assign unused_bits = ^{head_e.imm, head_e.pc};

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: RV64 default build and an RV32/LW/2-bit-counter
// build driven in lockstep, checked against a queue-based reference model.
module tb_decode_stage;

  typedef struct packed {
    logic        illegal;
    logic [11:0] ctrl;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] pc;
  } view_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        rdy64, val64, ill64, rdy32, val32, ill32;
  logic [11:0] ctrl64, ctrl32;
  logic [63:0] imm64;
  logic [31:0] imm32, pc64, pc32;
  logic [4:0]  rs1_64, rs2_64, rd_64, rs1_32, rs2_32, rd_32;
  logic [2:0]  f3_64, f3_32;
  logic [15:0] cnt64;
  logic [1:0]  cnt32;
  view_t       obs64, obs32;

  item_t       q[$];
  int          m_cnt64, m_cnt32;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] pc_ctr = 32'h1000;

  always #5 clk = ~clk;

  decode_stage dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(val64),
    .out_ready(out_ready), .out_ctrl(ctrl64), .out_imm(imm64), .out_rs1(rs1_64),
    .out_rs2(rs2_64), .out_rd(rd_64), .out_funct3(f3_64), .out_pc(pc64),
    .out_illegal(ill64), .ill_count(cnt64)
  );

  decode_stage #(.XLEN(32), .MEM_F3(3'd2), .ILL_CNT_W(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(val32),
    .out_ready(out_ready), .out_ctrl(ctrl32), .out_imm(imm32), .out_rs1(rs1_32),
    .out_rs2(rs2_32), .out_rd(rd_32), .out_funct3(f3_32), .out_pc(pc32),
    .out_illegal(ill32), .ill_count(cnt32)
  );

  assign obs64 = {ill64, ctrl64, imm64, rs1_64, rs2_64, rd_64, f3_64, pc64};
  assign obs32 = {ill32, ctrl32, {32'b0, imm32}, rs1_32, rs2_32, rd_32, f3_32, pc32};

  // Reference decode written directly from the ISA rules.
  function automatic view_t model_view(input logic [31:0] ins, input logic [31:0] pc, input bit x64);
    view_t  v;
    int     f3, f7, hi, sra, memf3, ctrl;
    longint imm;
    bit     ok;
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    memf3 = x64 ? 3 : 2;
    imm = 0;
    ctrl = 0;
    ok = 1;
    case (ins[6:0])
      7'h33: begin
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        ctrl = 'h020 + f3 + ((f7 == 32) ? 8 : 0);
      end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          hi  = x64 ? int'(ins[31:26]) : int'(ins[31:25]);
          sra = x64 ? 16 : 32;
          ok  = (hi == 0) || (f3 == 5 && hi == sra);
          imm = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
          ctrl = 'h030 + f3 + ((hi == sra) ? 8 : 0);
        end else begin
          imm = longint'($signed(ins[31:20]));
          ctrl = 'h030 + f3;
        end
      end
      7'h03: begin ok = (f3 == memf3); ctrl = 'h170; imm = longint'($signed(ins[31:20])); end
      7'h23: begin ok = (f3 == memf3); ctrl = 'h090; imm = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin
        ok = (f3 < 2); ctrl = 'h208;
        imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'h6f: begin ctrl = 'h820; imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
      7'h67: begin ctrl = 'h420; imm = longint'($signed(ins[31:20])); end
      default: ok = 0;
    endcase
    if (!x64) imm = imm & 64'h0000_0000_FFFF_FFFF;
    if (!ok) begin ctrl = 0; imm = 0; end
    v.illegal = !ok;
    v.ctrl    = ctrl[11:0];
    v.imm     = imm;
    v.rs1     = ins[19:15];
    v.rs2     = ins[24:20];
    v.rd      = ins[11:7];
    v.f3      = ins[14:12];
    v.pc      = pc;
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opcs [8];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h7f};
    r = $urandom;
    r[6:0] = opcs[$urandom_range(7)];
    case ($urandom_range(4))
      0, 1: r[31:25] = 7'h00;
      2:    r[31:25] = 7'h20;
      3:    r[31:25] = 7'h21;
      default: ;
    endcase
    if ($urandom_range(3) == 0) r[14:12] = $urandom_range(1) ? 3'd3 : 3'd2;
    return r;
  endfunction

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic tick();
    bit    push, pop;
    item_t e;
    @(posedge clk);
    if (rst_n) begin
      if (flush) begin
        q.delete();
      end else begin
        push = in_valid && (q.size() < 2);
        pop  = (q.size() != 0) && out_ready;
        if (pop) begin
          e = q.pop_front();
          if (model_view(e.instr, e.pc, 1'b1).illegal && m_cnt64 < 65535) m_cnt64++;
          if (model_view(e.instr, e.pc, 1'b0).illegal && m_cnt32 < 3) m_cnt32++;
        end
        if (push) q.push_back('{in_instr, in_pc});
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc_ctr;
    pc_ctr   = pc_ctr + 32'd4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    q.delete(); m_cnt64 = 0; m_cnt32 = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rdy64 !== 1'b1 || rdy32 !== 1'b1 || val64 !== 1'b0 || val32 !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs: rdy=%b%b val=%b%b want rdy=11 val=00", rdy64, rdy32, val64, val32);
    end
    n_checks++;
    if (obs64 !== '0 || obs32 !== '0 || cnt64 !== '0 || cnt32 !== '0) begin
      n_fail++; $display("FAIL reset_out: obs64=%h obs32=%h cnt=%0d/%0d want all zero", obs64, obs32, cnt64, cnt32);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] ins [3];
    logic [11:0] cw  [3];
    ins = '{32'h002081B3, 32'hFFF00093, 32'hFE209EE3};
    cw  = '{12'h020, 12'h030, 12'h208};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ins[i]);
      tick();
      n_checks++;
      if (val64 !== 1'b1 || ctrl64 !== cw[i] || ctrl32 !== cw[i]) begin
        n_fail++; $display("FAIL dir_ctrl[%0d]: val=%b ctrl=%h/%h want val=1 ctrl=%h", i, val64, ctrl64, ctrl32, cw[i]);
      end
      n_checks++;
      if (obs64 !== model_view(q[0].instr, q[0].pc, 1'b1) || obs32 !== model_view(q[0].instr, q[0].pc, 1'b0)) begin
        n_fail++; $display("FAIL dir_view[%0d]: got %h / %h want %h / %h", i, obs64, obs32,
                           model_view(q[0].instr, q[0].pc, 1'b1), model_view(q[0].instr, q[0].pc, 1'b0));
      end
      n_checks++;
      case (i)
        0: if (rd_64 !== 5'd3 || rs1_64 !== 5'd1 || rs2_64 !== 5'd2 || imm64 !== '0) begin
             n_fail++; $display("FAIL add_fields: rd=%0d rs1=%0d rs2=%0d imm=%h want 3 1 2 0", rd_64, rs1_64, rs2_64, imm64);
           end
        1: if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFF || imm32 !== 32'hFFFF_FFFF) begin
             n_fail++; $display("FAIL addi_imm: got %h / %h want all ones", imm64, imm32);
           end
        default: if (f3_64 !== 3'b001 || imm64 !== 64'hFFFF_FFFF_FFFF_FFFC || imm32 !== 32'hFFFF_FFFC) begin
             n_fail++; $display("FAIL bne_imm: f3=%b imm=%h/%h want 001 -4", f3_64, imm64, imm32);
           end
      endcase
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (val64 !== 1'b0 || val32 !== 1'b0) begin
      n_fail++; $display("FAIL dir_drain: val=%b%b want 00", val64, val32);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_i [3];
    logic [31:0] exp_p [3];
    int          got;
    bit          accepted;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_i[k] = 32'h00000033 | (32'(k + 5) << 7) | (32'(k + 1) << 15) | (32'(k + 2) << 20);
      exp_p[k] = pc_ctr;
      drive(exp_i[k]);
      tick();
    end
    // third offer still pending: buffer full
    n_checks++;
    if (rdy64 !== 1'b0 || rdy32 !== 1'b0 || val64 !== 1'b1) begin
      n_fail++; $display("FAIL bp_full: rdy=%b%b val=%b want rdy=00 val=1", rdy64, rdy32, val64);
    end
    tick();
    n_checks++;
    if (obs64 !== model_view(exp_i[0], exp_p[0], 1'b1)) begin
      n_fail++; $display("FAIL bp_hold: got %h want %h", obs64, model_view(exp_i[0], exp_p[0], 1'b1));
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      if (val64) begin
        n_checks++;
        if (obs64 !== model_view(exp_i[got], exp_p[got], 1'b1)) begin
          n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", got, obs64, model_view(exp_i[got], exp_p[got], 1'b1));
        end
        got++;
      end
      accepted = in_valid && rdy64;
      tick();
      if (accepted) in_valid = 1'b0;
    end
    n_checks++;
    if (got !== 3 || val64 !== 1'b0 || val32 !== 1'b0) begin
      n_fail++; $display("FAIL bp_count: emerged=%0d val=%b%b want 3 and empty", got, val64, val32);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(32'h00B50533); tick();
    drive(32'h40C585B3); tick();
    drive(32'h00D60633);
    flush = 1'b1;
    n_checks++;
    if (val64 !== 1'b1 || rdy64 !== 1'b0) begin
      n_fail++; $display("FAIL flush_pre: val=%b rdy=%b want 1 0", val64, rdy64);
    end
    out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (val64 !== 1'b0 || val32 !== 1'b0 || rdy64 !== 1'b1 || rdy32 !== 1'b1) begin
      n_fail++; $display("FAIL flush_post: val=%b%b rdy=%b%b want val=00 rdy=11", val64, val32, rdy64, rdy32);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (val64 !== 1'b0 || val32 !== 1'b0) begin
        n_fail++; $display("FAIL flush_ghost[%0d]: val=%b%b want 00", c, val64, val32);
      end
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(32'hFFFFFFFF); tick();
    n_checks++;
    if (ill64 !== 1'b1 || ill32 !== 1'b1 || ctrl64 !== '0 || ctrl32 !== '0 || imm64 !== '0 || imm32 !== '0) begin
      n_fail++; $display("FAIL ill_ones: ill=%b%b ctrl=%h/%h imm=%h/%h want 11 0 0", ill64, ill32, ctrl64, ctrl32, imm64, imm32);
    end
    drive(32'h02009093); tick();
    n_checks++;
    if (ill32 !== 1'b1 || ctrl32 !== '0 || ill64 !== 1'b0 || ctrl64 !== 12'h031 || imm64 !== 64'd32) begin
      n_fail++; $display("FAIL ill_slli: ill32=%b ctrl32=%h ill64=%b ctrl64=%h imm64=%h want 1 0 0 031 20",
                         ill32, ctrl32, ill64, ctrl64, imm64);
    end
    in_valid = 1'b0; tick();
    n_checks++;
    if (cnt32 !== 2'd2 || cnt64 !== 16'd1) begin
      n_fail++; $display("FAIL ill_cnt2: cnt32=%0d cnt64=%0d want 2 1", cnt32, cnt64);
    end
    for (int k = 0; k < 3; k++) begin drive(32'hFFFFFFFF); tick(); end
    in_valid = 1'b0; tick();
    n_checks++;
    if (cnt32 !== 2'd3 || cnt64 !== 16'd4) begin
      n_fail++; $display("FAIL ill_sat: cnt32=%0d cnt64=%0d want 3 4", cnt32, cnt64);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(19) == 0);
      n_checks++;
      if (rdy64 !== (q.size() < 2) || rdy32 !== (q.size() < 2) ||
          val64 !== (q.size() != 0) || val32 !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_hs[%0d]: rdy=%b%b val=%b%b model size=%0d", c, rdy64, rdy32, val64, val32, q.size());
      end
      if (q.size() != 0) begin
        n_checks++;
        if (obs64 !== model_view(q[0].instr, q[0].pc, 1'b1)) begin
          n_fail++; $display("FAIL rnd_v64[%0d]: instr=%h got %h want %h", c, q[0].instr, obs64, model_view(q[0].instr, q[0].pc, 1'b1));
        end
        n_checks++;
        if (obs32 !== model_view(q[0].instr, q[0].pc, 1'b0)) begin
          n_fail++; $display("FAIL rnd_v32[%0d]: instr=%h got %h want %h", c, q[0].instr, obs32, model_view(q[0].instr, q[0].pc, 1'b0));
        end
      end
      n_checks++;
      if (cnt64 !== 16'(m_cnt64) || cnt32 !== 2'(m_cnt32)) begin
        n_fail++; $display("FAIL rnd_cnt[%0d]: cnt=%0d/%0d want %0d/%0d", c, cnt64, cnt32, m_cnt64, m_cnt32);
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    drive(32'h00310233); tick();
    drive(32'h00418293); tick();
    in_valid = 1'b0;
    n_checks++;
    if (val64 !== 1'b1 || rdy64 !== 1'b0) begin
      n_fail++; $display("FAIL rstm_pre: val=%b rdy=%b want 1 0", val64, rdy64);
    end
    #2 rst_n = 1'b0;
    q.delete(); m_cnt64 = 0; m_cnt32 = 0;
    #1;
    n_checks++;
    if (obs64 !== '0 || obs32 !== '0 || val64 !== 1'b0 || rdy64 !== 1'b1 || cnt64 !== '0 || cnt32 !== '0) begin
      n_fail++; $display("FAIL rstm_async: obs64=%h obs32=%h val=%b rdy=%b cnt=%0d/%0d want zeros rdy=1",
                         obs64, obs32, val64, rdy64, cnt64, cnt32);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    drive(32'h002081B3); tick();
    in_valid = 1'b0;
    n_checks++;
    if (ctrl64 !== 12'h020 || obs64 !== model_view(q[0].instr, q[0].pc, 1'b1) ||
        obs32 !== model_view(q[0].instr, q[0].pc, 1'b0)) begin
      n_fail++; $display("FAIL rstm_after: got %h want %h", obs64, model_view(q[0].instr, q[0].pc, 1'b1));
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
